mpadder_arbiter: RTL
====================

// Module: mpadder_arbiter
// PURPOSE
// Shares one mpadder (1027-bit multi-cycle add/subtract unit) between NREQ requesters
// in the Montgomery datapath, e.g. the accumulate stage and the final conditional
// subtraction. Grants round-robin, latches the winner's operands and sequences the
// adder's start/done handshake. Returns the result to the winner and guards against
// a hung adder with a watchdog.
// PARAMETERS
// NREQ     2     number of requesters (2..8)
// WIDTH    1027  operand width; result is WIDTH+1 bits
// TIMEOUT  16    max cycles from add_start to add_done before error response
// PORTS
// clk          in   1             rising-edge clock
// resetn       in   1             async active-low reset
// req          in   NREQ          per-requester request level
// req_sub      in   NREQ          per-requester op: 1=a-b, 0=a+b
// req_a        in   NREQ*WIDTH    operand A, slice i = requester i
// req_b        in   NREQ*WIDTH    operand B, slice i = requester i
// gnt          out  NREQ          one-hot grant, held LAUNCH..RESP
// rsp_valid    out  NREQ          one-cycle pulse to the winner, result valid
// rsp_err      out  1             qualifies rsp_valid: watchdog expired
// rsp_result   out  WIDTH+1       result, held until next RESP
// busy         out  1             high in any state except IDLE
// add_start    out  1             to mpadder start
// add_subtract out  1             to mpadder subtract
// add_in_a     out  WIDTH         to mpadder in_a, from latched operand
// add_in_b     out  WIDTH         to mpadder in_b, from latched operand
// add_result   in   WIDTH+1       from mpadder result
// add_done     in   1             from mpadder done
// BEHAVIOUR
// - Reset (async): state=IDLE, rr_ptr=0, gnt/rsp_valid/rsp_err/add_start/busy=0.
//   Clears rsp_result and operand regs to 0. mpadder shares resetn.
// - FSM IDLE->LAUNCH->WAIT->RESP->IDLE, all transitions registered.
// - IDLE
//   - If req!=0, pick first set bit scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//   - Latch the winner's req_a, req_b, req_sub into op regs; set gnt one-hot; go LAUNCH.
// - LAUNCH: add_start=1 for exactly this cycle; clear watchdog; go WAIT.
// - WAIT
//   - add_done=1: capture add_result into rsp_result, rsp_err=0, go RESP.
//   - Otherwise watchdog +1; at watchdog==TIMEOUT: rsp_err=1, rsp_result=0, go RESP.
// - RESP
//   - rsp_valid[winner]=1 for one cycle; rr_ptr <= winner+1 mod NREQ.
//   - gnt clears on exit; go IDLE.
// - Operand timing
//   - add_in_a/add_in_b/add_subtract driven only from op regs.
//   - These are stable from LAUNCH until the next IDLE grant, as mpadder re-samples
//     inputs every cycle.
//   - Requester inputs are don't-care after the grant cycle.
// - Adder restart spacing: add_done to next add_start >= 3 cycles (RESP, IDLE,
//   LAUNCH), which covers mpadder's post-done state.
// - Latency: req seen in IDLE at cycle 0 -> add_start at cycle 1; rsp_valid exactly
//   1 cycle after add_done is sampled high.
// - Request rules
//   - Requester holds req until its rsp_valid.
//   - req still high the cycle after rsp_valid is a new request.
//   - Dropping req while granted does not abort; rsp_valid is still issued.
// - add_done outside WAIT is ignored. req/req_sub changes outside IDLE are ignored.
// - Result width: rsp_result = add_result, WIDTH+1 bits, no truncation. Subtract
//   result is mpadder's two's-complement form; bit WIDTH is the borrow indicator.
// TESTING
// 1. Single add: req=01, a=5, b=3, sub=0 -> add_start 1 cycle later;
//    rsp_valid=01, rsp_result=8, rsp_err=0.
// 2. Subtract: req=10, a=10, b=3, sub=1 -> rsp_valid=10, rsp_result[WIDTH-1:0]=7.
// 3. Round-robin fairness: req=11 held continuously -> grants 01,10,01,10.
//    Each pair of rsp_valid pulses is separated by >= 3 cycles after add_done.
// 4. Operand latch: change req_a to all-ones the cycle after the grant, with a=1, b=1
//    -> rsp_result=2.
// 5. Watchdog: adder model never asserts done -> rsp_valid plus rsp_err=1
//    exactly TIMEOUT+1 cycles after add_start.
// 6. Reset mid-WAIT: deassert resetn -> gnt/busy/rsp_valid=0 immediately
//    and no stale response. Next req is granted to requester 0.

Source files
------------

// File: rtl/mpadder_arbiter.sv
// rtl/mpadder_arbiter.sv - round-robin arbiter sharing one mpadder between requesters
module mpadder_arbiter #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 1027,
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         req_sub,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic                    rsp_err,
  output logic [WIDTH:0]          rsp_result,
  output logic                    busy,
  output logic                    add_start,
  output logic                    add_subtract,
  output logic [WIDTH-1:0]        add_in_a,
  output logic [WIDTH-1:0]        add_in_b,
  input  logic [WIDTH:0]          add_result,
  input  logic                    add_done
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW1 = PW + 1;
  localparam int WW  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} stateType;

  stateType        state;
  stateType        stateNext;
  logic [PW-1:0]   rrPtr;
  logic [PW-1:0]   winIdx;
  logic [PW-1:0]   pickIdx;
  logic [PW-1:0]   ptrNext;
  logic [PW1-1:0]  ptrSum;
  logic [PW1-1:0]  ptrInc;
  logic            pickValid;
  logic [NREQ-1:0] reqRot;
  logic [NREQ-1:0] gntReg;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic            opSub;
  logic [WW-1:0]   wdog;
  logic [WW-1:0]   wdogInc;
  logic            wdogHit;
  logic [WIDTH:0]  rspResult;
  logic            rspErr;

  // Rotate requests so bit 0 is rr_ptr, take the first set bit, map back to a requester index
  always_comb begin
    reqRot    = NREQ'({req, req} >> rrPtr);
    pickValid = 1'b0;
    pickIdx   = '0;
    ptrSum    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (reqRot[k]) begin
        ptrSum = {1'b0, rrPtr} + PW1'(k);
        if (ptrSum >= PW1'(NREQ)) begin
          ptrSum = ptrSum - PW1'(NREQ);
        end
        pickValid = 1'b1;
        pickIdx   = ptrSum[PW-1:0];
      end
    end
    ptrInc  = {1'b0, winIdx} + PW1'(1);
    ptrNext = (ptrInc >= PW1'(NREQ)) ? '0 : ptrInc[PW-1:0];
    wdogInc = wdog + WW'(1);
    wdogHit = (wdogInc == WW'(TIMEOUT));
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // FSM next-state: every step is registered, done beats the watchdog in the same cycle
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (pickValid) stateNext = LAUNCH;
      LAUNCH:  stateNext = WAIT;
      WAIT:    if (add_done || wdogHit) stateNext = RESP;
      RESP:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state
  always_comb begin
    busy      = (state != IDLE);
    add_start = (state == LAUNCH);
    rsp_valid = (state == RESP) ? gntReg : '0;
  end

  // Operand latch, grant, watchdog, response capture and pointer advance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rrPtr     <= '0;
      winIdx    <= '0;
      gntReg    <= '0;
      opA       <= '0;
      opB       <= '0;
      opSub     <= 1'b0;
      wdog      <= '0;
      rspResult <= '0;
      rspErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pickValid) begin
            opA    <= req_a[pickIdx*WIDTH +: WIDTH];
            opB    <= req_b[pickIdx*WIDTH +: WIDTH];
            opSub  <= req_sub[pickIdx];
            winIdx <= pickIdx;
            gntReg <= NREQ'(1) << pickIdx;
          end
        end
        LAUNCH: wdog <= '0;
        WAIT: begin
          if (add_done) begin
            rspResult <= add_result;
            rspErr    <= 1'b0;
          end else begin
            wdog <= wdogInc;
            if (wdogHit) begin
              rspResult <= '0;
              rspErr    <= 1'b1;
            end
          end
        end
        RESP: begin
          rrPtr  <= ptrNext;
          gntReg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign gnt          = gntReg;
  assign rsp_err      = rspErr;
  assign rsp_result   = rspResult;
  assign add_in_a     = opA;
  assign add_in_b     = opB;
  assign add_subtract = opSub;

endmodule
